// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM states, requester ids and default timing for the RAM access arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    localparam int DEF_RAM_LAT = 4;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2: combinational two-way round-robin picker; on a tie the port not served last wins.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = req_a || req_b;
    assign grant_id    = (req_a && req_b) ? ((last_grant == REQ_A) ? REQ_B : REQ_A)
                                          : (req_b ? REQ_B : REQ_A);
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin sharing of one RAM between ports A and B, turning
// single-word requests into the RAM's edge-triggered strobe protocol with timeout.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_LAT    = DEF_RAM_LAT,
    parameter int TIMEOUT    = DEF_TIMEOUT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic                  err_a,
    output logic                  err_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_data_wr,
    output logic                  ram_rd_ins,
    output logic                  ram_wr_ins,
    input  logic [DATA_WIDTH-1:0] ram_data_rd,
    input  logic                  ram_flag_rd,
    input  logic                  ram_flag_wr,
    output logic                  busy
);
    localparam int CW = $clog2(TIMEOUT);

    state_t                r_state, w_next;
    logic                  r_id, r_we, r_err, r_last;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata_a, r_rdata_b;
    logic                  w_gv, w_gid, w_flag, w_ok, w_to;

    ram_arb_rr2 u_rr (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (r_last),
        .grant_valid (w_gv),
        .grant_id    (w_gid)
    );

    // The flag is only trusted once the RAM latency has elapsed; before that it may be stale.
    assign w_flag = r_we ? ram_flag_wr : ram_flag_rd;
    assign w_ok   = (r_cnt >= CW'(RAM_LAT - 1)) && w_flag;
    assign w_to   = r_cnt == CW'(TIMEOUT - 1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_gv ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (w_ok || w_to) ? DONE : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_id      <= REQ_A;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_last    <= REQ_B;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && w_gv) begin
                r_id    <= w_gid;
                r_last  <= w_gid;
                r_we    <= (w_gid == REQ_B) ? we_b : we_a;
                r_addr  <= (w_gid == REQ_B) ? addr_b : addr_a;
                r_wdata <= (w_gid == REQ_B) ? wdata_b : wdata_a;
            end
            if (r_state == WAIT && w_next == DONE) begin
                r_err <= !w_ok;
                if (!r_we && r_id == REQ_A) r_rdata_a <= ram_data_rd;
                if (!r_we && r_id == REQ_B) r_rdata_b <= ram_data_rd;
            end
        end
    end

    assign ack_a       = (r_state == DONE) && (r_id == REQ_A);
    assign ack_b       = (r_state == DONE) && (r_id == REQ_B);
    assign err_a       = ack_a && r_err;
    assign err_b       = ack_b && r_err;
    assign rdata_a     = r_rdata_a;
    assign rdata_b     = r_rdata_b;
    assign ram_addr_rd = r_addr;
    assign ram_addr_wr = r_addr;
    assign ram_data_wr = r_wdata;
    assign ram_rd_ins  = (r_state == ISSUE) && !r_we;
    assign ram_wr_ins  = (r_state == ISSUE) && r_we;
    assign busy        = r_state != IDLE;
endmodule
